// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control FSM.
// Steps the shared PC/IR/regfile/ALU datapath forward one state per clock.
// Every memory-access state waits for MIO_ready before it moves on.
//
// state | meaning
// ------+-----------------------------------------------------------
// IF  0 | fetch: read mem[PC], PC+4; IR/PC load when ready
// ID  1 | decode; branch target PC+(imm<<2) into ALUOut
// MA  2 | memory address A+sext(imm) into ALUOut
// MRD 3 | load read from mem[ALUOut], hold until ready
// MWB 4 | load write-back MDR -> rt
// MWR 5 | store write to mem[ALUOut], single strobe on ready
// EXR 6 | R-type execute, A op B
// RWB 7 | R-type write-back ALU result -> rd
// BEQ 8 | compare A-B, load PC from ALUOut if zero
// JMP 9 | load PC with jump target
// EXI 10| immediate execute (addi/slti), A op sext(imm)
// IWB 11| immediate write-back ALUOut -> rt
module mcpu_ctrl #(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       mem_w,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] ALU_Control,
  output logic       CPU_MIO,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MRD = 4'd3,
    S_MWB = 4'd4,
    S_MWR = 4'd5,
    S_EXR = 4'd6,
    S_RWB = 4'd7,
    S_BEQ = 4'd8,
    S_JMP = 4'd9,
    S_EXI = 4'd10,
    S_IWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_t     st, st_nxt;
  logic       rdy;
  logic [2:0] fun_alu;

  // With MEM_WAIT cleared the bus is assumed to complete every access at once.
  assign rdy   = MEM_WAIT ? MIO_ready : 1'b1;
  assign state = st;

  // State register; reset forces fetch so an in-flight instruction is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_IF;
    else     st <= st_nxt;
  end

  // R-type function field to ALU operation; unknown codes fall back to add.
  always_comb begin
    fun_alu = 3'b010;
    case (Fun)
      6'b100000: fun_alu = 3'b010;
      6'b100010: fun_alu = 3'b110;
      6'b100100: fun_alu = 3'b000;
      6'b100101: fun_alu = 3'b001;
      6'b101010: fun_alu = 3'b111;
      6'b100111: fun_alu = 3'b100;
      6'b000010: fun_alu = 3'b101;
      6'b010110: fun_alu = 3'b011;
      default:   fun_alu = 3'b010;
    endcase
  end

  // Next-state and datapath controls, decoded from the current state.
  always_comb begin
    st_nxt      = S_IF;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    mem_w       = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALU_Control = 3'b010;
    CPU_MIO     = 1'b0;
    illegal     = 1'b0;
    case (st)
      S_IF: begin
        MemRead = 1'b1;
        CPU_MIO = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = rdy;
        PCWrite = rdy;
        st_nxt  = rdy ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        case (OPcode)
          OP_RTYPE:       st_nxt = S_EXR;
          OP_LW, OP_SW:   st_nxt = S_MA;
          OP_BEQ:         st_nxt = S_BEQ;
          OP_J:           st_nxt = S_JMP;
          OP_SLTI, OP_ADDI: st_nxt = S_EXI;
          default: begin
            // PC was already advanced in IF, so the bad word is simply skipped.
            illegal = 1'b1;
            st_nxt  = S_IF;
          end
        endcase
      end
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        st_nxt  = (OPcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
        st_nxt  = rdy ? S_MWB : S_MRD;
      end
      S_MWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MWR: begin
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
        // Strobe only on the completing cycle so one store writes exactly once.
        mem_w   = rdy;
        st_nxt  = rdy ? S_IF : S_MWR;
      end
      S_EXR: begin
        ALUSrcA     = 1'b1;
        ALU_Control = fun_alu;
        st_nxt      = S_RWB;
      end
      S_RWB: begin
        RegWrite    = 1'b1;
        RegDst      = 1'b1;
        ALU_Control = fun_alu;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALU_Control = 3'b110;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_EXI: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = 2'b10;
        ALU_Control = (OPcode == OP_SLTI) ? 3'b111 : 3'b010;
        st_nxt      = S_IWB;
      end
      S_IWB: begin
        RegWrite = 1'b1;
      end
      default: begin
        // Unused encodings: recover to fetch with every control inactive.
        ALU_Control = 3'b000;
        st_nxt      = S_IF;
      end
    endcase
  end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed bench for the multi-cycle control FSM.
module tb_mcpu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       MIO_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, mem_w, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, ALUSrcA, CPU_MIO, illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALU_Control;
  logic [3:0] state;

  int n_vec  = 0;
  int n_bad  = 0;
  int memw_n = 0;
  int rw_n   = 0;
  int cyc_n  = 0;

  mcpu_ctrl #(.MEM_WAIT(1'b1)) dut (
    .clk(clk), .rst(rst), .OPcode(OPcode), .Fun(Fun), .MIO_ready(MIO_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .mem_w(mem_w), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALU_Control(ALU_Control), .CPU_MIO(CPU_MIO), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] fun;
    logic [2:0] alu;
  } rvec_t;

  rvec_t tbl[9];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance to the next cycle: drive ready away from the edge, then sample.
  task automatic step(input logic rdy);
    @(negedge clk);
    MIO_ready = rdy;
    #1;
    cyc_n++;
    if (mem_w === 1'b1) memw_n++;
    if (RegWrite === 1'b1) rw_n++;
  endtask

  task automatic run_r(input logic [5:0] fun, input logic [2:0] alu);
    OPcode = 6'b000000;
    Fun    = fun;
    step(1); chk("r_if_state", {4'd0, state}, 8'd0); chk("r_if_irwrite", {7'd0, IRWrite}, 8'd1);
    step(1); chk("r_id_state", {4'd0, state}, 8'd1); chk("r_id_srcb", {6'd0, ALUSrcB}, 8'd3);
    step(1); chk("r_exr_state", {4'd0, state}, 8'd6); chk("r_exr_alu", {5'd0, ALU_Control}, {5'd0, alu});
    chk("r_exr_regwrite", {7'd0, RegWrite}, 8'd0);
    step(1); chk("r_rwb_state", {4'd0, state}, 8'd7); chk("r_rwb_alu", {5'd0, ALU_Control}, {5'd0, alu});
    chk("r_rwb_regwrite", {7'd0, RegWrite}, 8'd1); chk("r_rwb_regdst", {7'd0, RegDst}, 8'd1);
    step(0); chk("r_end_state", {4'd0, state}, 8'd0); chk("r_end_regwrite", {7'd0, RegWrite}, 8'd0);
  endtask

  initial begin
    tbl[0] = '{6'b100000, 3'b010};
    tbl[1] = '{6'b100010, 3'b110};
    tbl[2] = '{6'b100100, 3'b000};
    tbl[3] = '{6'b100101, 3'b001};
    tbl[4] = '{6'b101010, 3'b111};
    tbl[5] = '{6'b100111, 3'b100};
    tbl[6] = '{6'b000010, 3'b101};
    tbl[7] = '{6'b010110, 3'b011};
    tbl[8] = '{6'b111111, 3'b010};

    rst = 1'b1; OPcode = 6'd0; Fun = 6'b100000; MIO_ready = 1'b1;
    step(1);
    chk("rst_state", {4'd0, state}, 8'd0);
    chk("rst_memread", {7'd0, MemRead}, 8'd1);
    chk("rst_cpu_mio", {7'd0, CPU_MIO}, 8'd1);
    chk("rst_srcb", {6'd0, ALUSrcB}, 8'd1);
    chk("rst_regwrite", {7'd0, RegWrite}, 8'd0);
    rst = 1'b0;
    MIO_ready = 1'b0;
    step(0);
    chk("if_stall_state", {4'd0, state}, 8'd0);
    chk("if_stall_irwrite", {7'd0, IRWrite}, 8'd0);
    chk("if_stall_pcwrite", {7'd0, PCWrite}, 8'd0);

    for (int i = 0; i < 9; i++) run_r(tbl[i].fun, tbl[i].alu);

    // lw with three stalled cycles in MRD: 8 cycles total.
    OPcode = 6'b100011; rw_n = 0; cyc_n = 0;
    step(1); chk("lw_if", {4'd0, state}, 8'd0);
    step(1); chk("lw_id", {4'd0, state}, 8'd1);
    step(1); chk("lw_ma", {4'd0, state}, 8'd2); chk("lw_ma_srcb", {6'd0, ALUSrcB}, 8'd2);
    for (int i = 0; i < 3; i++) begin
      step(0); chk("lw_mrd_stall", {4'd0, state}, 8'd3);
    end
    step(1); chk("lw_mrd_done", {4'd0, state}, 8'd3);
    chk("lw_mrd_iord", {7'd0, IorD}, 8'd1); chk("lw_mrd_memread", {7'd0, MemRead}, 8'd1);
    step(1); chk("lw_mwb", {4'd0, state}, 8'd4);
    chk("lw_mwb_memtoreg", {7'd0, MemtoReg}, 8'd1); chk("lw_mwb_regwrite", {7'd0, RegWrite}, 8'd1);
    chk("lw_mwb_regdst", {7'd0, RegDst}, 8'd0);
    chk("lw_cycles", cyc_n[7:0], 8'd8);
    step(0); chk("lw_end", {4'd0, state}, 8'd0);
    chk("lw_regwrite_count", rw_n[7:0], 8'd1);

    // sw with ready held off two cycles in MWR.
    OPcode = 6'b101011; rw_n = 0; memw_n = 0;
    step(1); chk("sw_if", {4'd0, state}, 8'd0);
    step(1); chk("sw_id", {4'd0, state}, 8'd1);
    step(1); chk("sw_ma", {4'd0, state}, 8'd2);
    step(0); chk("sw_mwr_w0", {4'd0, state}, 8'd5); chk("sw_memw_wait", {7'd0, mem_w}, 8'd0);
    step(0); chk("sw_mwr_w1", {4'd0, state}, 8'd5);
    step(1); chk("sw_mwr_go", {4'd0, state}, 8'd5); chk("sw_memw_go", {7'd0, mem_w}, 8'd1);
    step(0); chk("sw_end", {4'd0, state}, 8'd0);
    chk("sw_memw_count", memw_n[7:0], 8'd1);
    chk("sw_regwrite_count", rw_n[7:0], 8'd0);

    // beq
    OPcode = 6'b000100;
    step(1); chk("beq_if", {4'd0, state}, 8'd0);
    step(1); chk("beq_id", {4'd0, state}, 8'd1);
    step(1); chk("beq_state", {4'd0, state}, 8'd8);
    chk("beq_pcwc", {7'd0, PCWriteCond}, 8'd1); chk("beq_alu", {5'd0, ALU_Control}, 8'd6);
    chk("beq_pcsrc", {6'd0, PCSource}, 8'd1);
    step(0); chk("beq_end", {4'd0, state}, 8'd0);

    // j
    OPcode = 6'b000010;
    step(1); chk("j_if", {4'd0, state}, 8'd0);
    step(1); chk("j_id", {4'd0, state}, 8'd1);
    step(1); chk("j_state", {4'd0, state}, 8'd9);
    chk("j_pcwrite", {7'd0, PCWrite}, 8'd1); chk("j_pcsrc", {6'd0, PCSource}, 8'd2);
    step(0); chk("j_end", {4'd0, state}, 8'd0);

    // slti
    OPcode = 6'b001010;
    step(1); step(1);
    step(1); chk("slti_exi", {4'd0, state}, 8'd10); chk("slti_alu", {5'd0, ALU_Control}, 8'd7);
    step(1); chk("slti_iwb", {4'd0, state}, 8'd11); chk("slti_regwrite", {7'd0, RegWrite}, 8'd1);
    step(0); chk("slti_end", {4'd0, state}, 8'd0);

    // addi
    OPcode = 6'b001000;
    step(1); step(1);
    step(1); chk("addi_exi", {4'd0, state}, 8'd10); chk("addi_alu", {5'd0, ALU_Control}, 8'd2);
    step(1); chk("addi_iwb", {4'd0, state}, 8'd11);
    step(0); chk("addi_end", {4'd0, state}, 8'd0);

    // illegal opcode
    OPcode = 6'h3f;
    step(1); chk("ill_if", {4'd0, state}, 8'd0); chk("ill_if_pulse", {7'd0, illegal}, 8'd0);
    step(1); chk("ill_id", {4'd0, state}, 8'd1); chk("ill_pulse", {7'd0, illegal}, 8'd1);
    step(0); chk("ill_next", {4'd0, state}, 8'd0); chk("ill_clear", {7'd0, illegal}, 8'd0);

    // reset during RWB aborts the write-back at once.
    OPcode = 6'b000000; Fun = 6'b100000;
    step(1); step(1); step(1);
    step(1); chk("abort_rwb", {4'd0, state}, 8'd7); chk("abort_rw_before", {7'd0, RegWrite}, 8'd1);
    rst = 1'b1;
    #1;
    chk("abort_state", {4'd0, state}, 8'd0);
    chk("abort_regwrite", {7'd0, RegWrite}, 8'd0);
    step(0); chk("abort_hold", {4'd0, state}, 8'd0);
    rst = 1'b0;
    step(0); chk("abort_after", {4'd0, state}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
